// File: rtl/fm_wm_row_reader_pkg.sv
// Shared types and sizing for the FM x WM product-memory read path.
package fm_wm_row_reader_pkg;

  localparam int unsigned FEATURE_ROWS   = 6;
  localparam int unsigned WEIGHT_COLS    = 3;
  localparam int unsigned DOT_PROD_WIDTH = 16;
  localparam int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS);
  localparam int unsigned WEIGHT_WIDTH   = $clog2(WEIGHT_COLS);
  localparam int unsigned NUM_ROWS_WIDTH = FEATURE_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Column 0 is the leftmost (most significant) element.
  typedef logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] row_t;

  // Requested row count limited to the physical memory depth.
  function automatic logic [NUM_ROWS_WIDTH-1:0] clamp_rows(input logic [NUM_ROWS_WIDTH-1:0] n);
    if (n > NUM_ROWS_WIDTH'(FEATURE_ROWS)) return NUM_ROWS_WIDTH'(FEATURE_ROWS);
    return n;
  endfunction

endpackage

// File: rtl/fm_wm_row_reader_if.sv
// Control, memory-read and row-stream signals of the product-memory row reader.
interface fm_wm_row_reader_if;
  import fm_wm_row_reader_pkg::*;

  logic                      start;
  logic [NUM_ROWS_WIDTH-1:0] num_rows;
  logic [FEATURE_WIDTH-1:0]  read_row;
  row_t                      fm_wm_row_in;
  logic                      row_valid;
  logic                      row_ready;
  row_t                      row_data;
  logic [FEATURE_WIDTH-1:0]  row_idx;
  logic [WEIGHT_WIDTH-1:0]   row_argmax;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, num_rows, fm_wm_row_in, row_ready,
    output read_row, row_valid, row_data, row_idx, row_argmax, busy, done
  );

  modport slave (
    output start, num_rows, fm_wm_row_in, row_ready,
    input  read_row, row_valid, row_data, row_idx, row_argmax, busy, done
  );

endinterface

// File: rtl/fm_wm_row_reader_row_argmax_unit.sv
// Combinational argmax over one product row; unsigned, ties go to the lowest column.
module row_argmax_unit
  import fm_wm_row_reader_pkg::*;
(
  input  row_t                    row,
  output logic [WEIGHT_WIDTH-1:0] idx_c
);

  logic [DOT_PROD_WIDTH-1:0] best;

  // Strict greater-than keeps the earliest column on ties.
  always_comb begin
    best  = row[0];
    idx_c = '0;
    for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
      if (row[c] > best) begin
        best  = row[c];
        idx_c = WEIGHT_WIDTH'(c);
      end
    end
  end

endmodule

// File: rtl/fm_wm_row_reader.sv
// Sweeps product-memory rows 0..limit-1 and streams each captured row with its index and argmax.
module fm_wm_row_reader
  import fm_wm_row_reader_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  fm_wm_row_reader_if.master  bus
);

  state_t                    state;
  logic [FEATURE_WIDTH-1:0]  counter;
  logic [NUM_ROWS_WIDTH-1:0] limit;
  logic [NUM_ROWS_WIDTH-1:0] start_limit_c;
  logic                      last_row_c;
  logic [WEIGHT_WIDTH-1:0]   argmax_c;

  logic                      row_valid_q;
  row_t                      row_data_q;
  logic [FEATURE_WIDTH-1:0]  row_idx_q;
  logic [WEIGHT_WIDTH-1:0]   row_argmax_q;
  logic                      busy_q;
  logic                      done_q;

  row_argmax_unit u_argmax (
    .row   (bus.fm_wm_row_in),
    .idx_c (argmax_c)
  );

  assign start_limit_c = clamp_rows(bus.num_rows);
  assign last_row_c    = (NUM_ROWS_WIDTH'(counter) + NUM_ROWS_WIDTH'(1)) == limit;

  // Sequencer; every output is a register updated on the transition that defines it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      limit        <= '0;
      row_valid_q  <= 1'b0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
      row_argmax_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            limit   <= start_limit_c;
            counter <= '0;
            if (start_limit_c == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= FETCH;
              busy_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          row_data_q   <= bus.fm_wm_row_in;
          row_idx_q    <= counter;
          row_argmax_q <= argmax_c;
          row_valid_q  <= 1'b1;
          state        <= PRESENT;
        end
        PRESENT: begin
          if (bus.row_ready) begin
            row_valid_q <= 1'b0;
            if (last_row_c) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              counter <= counter + FEATURE_WIDTH'(1);
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.read_row   = counter;
  assign bus.row_valid  = row_valid_q;
  assign bus.row_data   = row_data_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.row_argmax = row_argmax_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/fm_wm_row_reader.md
Name: fm_wm_row_reader

Overview:
- Read-side sequencer for the FM×WM product memory.
- On start, it walks the memory rows 0..N-1 by driving the memory's read-row address and capturing each combinationally returned row.
- Each captured row is presented downstream, together with its row index and per-row argmax, over a valid/ready handshake.
- It sits between the product memory and the downstream aggregation/argmax stage.

Parameters:
- FEATURE_ROWS, 6, number of rows in the product memory.
- WEIGHT_COLS, 3, number of columns per row.
- DOT_PROD_WIDTH, 16, element width; elements are treated as unsigned.
- FEATURE_WIDTH, $clog2(FEATURE_ROWS), row index width.
- WEIGHT_WIDTH, $clog2(WEIGHT_COLS), column index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a read sweep.
- num_rows  in  FEATURE_WIDTH+1  number of rows to read; sampled when start is accepted.
- read_row  out  FEATURE_WIDTH  row address driven to the product memory.
- fm_wm_row_in  in  DOT_PROD_WIDTH × [0:WEIGHT_COLS-1]  row data returned combinationally by the memory.
- row_valid  out  1  the row_* outputs hold a valid row.
- row_ready  in  1  downstream accepts the current row.
- row_data  out  DOT_PROD_WIDTH × [0:WEIGHT_COLS-1]  captured row.
- row_idx  out  FEATURE_WIDTH  index of the captured row.
- row_argmax  out  WEIGHT_WIDTH  column index of the maximum element in the captured row.
- busy  out  1  a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset: state IDLE; row counter, read_row, row_data, row_idx, row_argmax, row_valid, busy and done are all 0. Reset mid-sweep abandons the sweep immediately, with no done pulse.
- State IDLE:
  - busy=0. start=1 latches limit = min(num_rows, FEATURE_ROWS) and clears the counter.
  - If limit==0, go to DONE. Otherwise go to FETCH.
  - start is ignored in every other state.
- State FETCH (1 cycle):
  - busy=1; read_row = counter.
  - At the clock edge, capture row_data <= fm_wm_row_in, row_idx <= counter and row_argmax <= argmax(fm_wm_row_in), set row_valid <= 1, then go to PRESENT.
- State PRESENT:
  - row_valid=1. row_data, row_idx and row_argmax are held stable while row_ready=0.
  - On row_valid & row_ready: row_valid <= 0.
  - If counter == limit-1, go to DONE. Otherwise counter++ and go to FETCH.
- State DONE (1 cycle): done=1, busy=0, then go to IDLE. start in this cycle is ignored.
- read_row holds the counter value in every state and is never driven out of range.
- Argmax:
  - Unsigned comparison across columns 0..WEIGHT_COLS-1.
  - Ties resolve to the lowest column index; an all-zero row gives 0.
- Latency:
  - start sampled at edge k → FETCH during cycle k+1 → row_valid=1 from cycle k+2.
  - With row_ready held at 1: one row per 2 cycles, and done asserts 2·limit+1 cycles after the start edge.
- Memory contents must not change during a sweep. If they do, the value captured in FETCH wins.

Decomposition:
- Shared package: state enum {IDLE, FETCH, PRESENT, DONE} and a row array typedef (DOT_PROD_WIDTH × WEIGHT_COLS).
- One sub-module: row_argmax_unit, combinational, taking a row and returning the tie-low argmax index. It is reused by the downstream argmax stage.

Test Plan:
1. Preload rows r = {r·3, r·3+1, r·3+2} for r = 0..5; num_rows=6, row_ready=1, pulse start.
   → Six rows arrive in order with row_idx 0..5; row 5 data = {15,16,17}; row_argmax=2 on every row; done exactly 13 cycles after the start edge.
2. Row 2 = {7,9,9}, row 3 = {0,0,0}.
   → row_argmax=1 for row 2 and 0 for row 3.
3. row_ready held low for 4 cycles while row 1 is presented.
   → row_valid stays 1 with row_data/row_idx unchanged; FETCH of row 2 occurs only after the accept.
4. num_rows=0.
   → No row_valid at all; done pulses 1 cycle after the start edge. Separately, num_rows=9 (clamped to 6) → exactly 6 rows, then done.
5. Pulse start again mid-sweep.
   → Ignored; the sequence completes unaltered and there is a single done pulse.
6. Assert rst while in PRESENT at row 3.
   → All outputs go to 0 asynchronously and there is no done pulse; a new start afterwards begins again at row 0.
